output_gating: RTL
==================

# output_gating

Consumer end of the output collector's result stream. Accepts the 256-bit accumulated vectors (16 lanes × 16-bit signed) that arrive with a single-cycle valid and no backpressure, applies optional per-lane ReLU gating, and computes a per-lane nonzero mask. It tags the last vector of each tile and buffers results in a small FIFO. Results are presented to the writeback stage on a valid/ready handshake.

## Interface
- `LANES`, 16: lanes per vector (fixed at 16 for the 256-bit bus).
- `DW`, 16: bits per lane, two's complement.
- `FIFO_DEPTH`, 4: output FIFO entries; must be a power of two, ≥ 2.
- `CNT_W`, 16: tile counter width.

- `clk`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  one result vector present this cycle; cannot be stalled.
- `in_sum`  in  256  lane i = `in_sum[16i+15:16i]`, signed.
- `cfg_relu`  in  1  sampled with each `in_valid` beat; 1 = clamp negative lanes to 0.
- `cfg_tile_len`  in  CNT_W  vectors per tile; 0 is treated as 1.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  writeback accepts head this cycle.
- `out_data`  out  256  gated vector at head; 0 when `out_valid`=0.
- `out_mask`  out  16  bit i = 1 iff gated lane i ≠ 0; 0 when `out_valid`=0.
- `out_last`  out  1  head is the final vector of a tile; 0 when `out_valid`=0.
- `ovf`  out  1  sticky: a vector was dropped on a full FIFO.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current entry count.

## Operation
- Gating (combinational on input): lane' = (`cfg_relu` && lane[15]) ? 0 : lane. No saturation or width change. mask[i] = |lane'[i].
- Tile counter `cnt` (CNT_W): increments on every `in_valid` beat, including dropped ones, so tile alignment follows upstream. Beat is last when `cnt >= max(cfg_tile_len,1)-1`; on a last beat `cnt` resets to 0. Using `>=` makes a mid-tile shrink of `cfg_tile_len` close the tile at the next beat.
- Each FIFO entry stores {last, mask[15:0], data[255:0]}. The FIFO is show-ahead: outputs reflect the head entry directly.
- Push = `in_valid` && (not full || pop). Pop = `out_valid` && `out_ready`.
- Full with `in_valid` and no pop: the beat is dropped, `ovf` is set and held until `rst`, FIFO contents are unchanged, and `cnt` still advances.
- Full with `in_valid` and pop in the same cycle: the push is accepted and the level is unchanged.
- Empty: `out_valid`=0, so no pop can occur. There is no bypass; the entry written this edge is visible next cycle.
- Pointers wrap modulo `FIFO_DEPTH`. Level is tracked explicitly, so full and empty are distinguished at wrap.

## Timing
- Reset (sync, `rst`=1 at an edge) sets: `out_valid`=0, `out_data`=0, `out_mask`=0, `out_last`=0, `ovf`=0, `fifo_level`=0, `cnt`=0, both pointers 0.
- Reset mid-operation discards all buffered entries. Any `in_valid` in the reset cycle is ignored.
- Latency: `in_valid` sampled at edge t into an empty FIFO → `out_valid`=1 with that data during the cycle after edge t (1 cycle).
- Throughput: 1 vector per cycle in and out while `out_ready` is held at 1. The FIFO never fills in that case.
- `out_data`, `out_mask`, `out_last` are stable while `out_valid`=1 and `out_ready`=0.
- `ovf` rises in the cycle after the dropping edge.
- `fifo_level` updates at every edge: +1 on push only, −1 on pop only, unchanged on both or neither.

## Test plan
- Reset then single beat: `cfg_relu`=1, lanes alternating 0x0005/0xFFFB (+5/−5), `out_ready`=1 → next cycle `out_valid`=1 with lanes 0x0005/0x0000, `out_mask`=0x5555; `out_valid`=0 the following cycle.
- Same vector with `cfg_relu`=0 → data passes unchanged and `out_mask`=0xFFFF. An all-zero vector → `out_mask`=0x0000, `out_valid` still 1.
- Tiles: `cfg_tile_len`=3, 7 back-to-back beats with `out_ready`=1 → `out_last` on output beats 3 and 6 only. With `cfg_tile_len`=0, `out_last` on every beat.
- Overflow: `out_ready`=0, 5 beats with `FIFO_DEPTH`=4 → `fifo_level`=4, `ovf`=1 after the 5th. Raise `out_ready` → exactly beats 1–4 are output, in order.
- Full plus simultaneous pop: FIFO full, `out_ready`=1 and `in_valid`=1 for 3 cycles → no drop, `ovf` stays 0, `fifo_level` stays 4, and output order is preserved.
- Reset mid-stream: 3 entries buffered, assert `rst` for one cycle → `out_valid`=0, `fifo_level`=0, `cnt`=0. The next beat with `cfg_tile_len`=2 is not last; the second one is.

Source files
------------

// File: rtl/output_gating.sv
// Result-stream consumer: per-lane ReLU gating, nonzero mask, tile-last tagging, show-ahead output FIFO.
// Latency 1 cycle into an empty FIFO; input cannot stall, so beats arriving on a full FIFO without a pop are dropped and flagged in ovf.
module output_gating #(
  parameter int LANES      = 16,
  parameter int DW         = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [LANES*DW-1:0]           in_sum,
  input  logic                          cfg_relu,
  input  logic [CNT_W-1:0]              cfg_tile_len,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*DW-1:0]           out_data,
  output logic [LANES-1:0]              out_mask,
  output logic                          out_last,
  output logic                          ovf,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int VW = LANES * DW;
  localparam int EW = 1 + LANES + VW;

  logic [VW-1:0]    w_gated;
  logic [LANES-1:0] w_mask;

  always_comb begin
    w_gated = in_sum;
    w_mask  = '0;
    for (int i = 0; i < LANES; i++) begin
      if (cfg_relu && in_sum[i*DW+DW-1]) begin
        w_gated[i*DW +: DW] = '0;
      end
      w_mask[i] = |w_gated[i*DW +: DW];
    end
  end

  // Tile counter advances on every beat, dropped or not, to stay aligned with upstream.
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_len_m1;
  logic             w_last;

  assign w_len_m1 = (cfg_tile_len == '0) ? '0 : cfg_tile_len - CNT_W'(1);
  assign w_last   = (r_cnt >= w_len_m1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (in_valid) begin
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          r_ovf;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_head;

  assign w_full = (r_level == (AW+1)'(FIFO_DEPTH));
  assign w_pop  = out_valid && out_ready;
  assign w_push = in_valid && (!w_full || w_pop);

  // Storage needs no reset: contents are only observed through a nonzero level.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_last, w_mask, w_gated};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
      if (in_valid && w_full && !w_pop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign w_head     = r_mem[r_rd_ptr];
  assign out_valid  = (r_level != '0);
  assign out_data   = out_valid ? w_head[VW-1:0] : '0;
  assign out_mask   = out_valid ? w_head[VW +: LANES] : '0;
  assign out_last   = out_valid ? w_head[EW-1] : 1'b0;
  assign ovf        = r_ovf;
  assign fifo_level = r_level;

endmodule
